hdl_cmd_responder: RTL and testbench

- HDL-side responder for commands issued from the SystemC side of the co-simulation. This is the reverse direction of the HDL-to-SC time tick.
- The DPI bridge pushes commands over a valid/ready request channel. The block queues them, executes them one at a time against a small register file or a cycle-wait timer, and returns exactly one response per command.
- Each response is stamped with the free-running HDL tick count, so SC can correlate it with HDL time.

---
 rtl/hdl_cmd_pkg.sv | 31 +++
 rtl/hdl_cmd_fifo.sv | 67 ++++++
 rtl/hdl_cmd_responder.sv | 162 ++++++++++++++++
 tb/tb_hdl_cmd_responder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdl_cmd_pkg.sv
// Shared types for the HDL-side command responder.
//   op_e    : command opcodes issued from the SystemC side
//   state_e : responder FSM states
//   cmd_t   : one queued command {op, addr, data}
// The struct field widths match the responder's default ADDR_W/DATA_W.
package hdl_cmd_pkg;

  localparam int CMD_ADDR_W = 8;
  localparam int CMD_DATA_W = 32;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2,
    OP_WAIT  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  typedef struct packed {
    op_e                   op;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] data;
  } cmd_t;

endpackage

// File: rtl/hdl_cmd_fifo.sv
// Synchronous FIFO of cmd_t used to queue incoming commands.
// Ports:
//   clk, rst     : clock and synchronous active-high reset (flushes the queue)
//   push, din    : write request and command; ignored while full
//   pop, dout    : read request and head-of-queue command (valid when !empty)
//   full, empty  : occupancy flags
//   count        : number of queued commands, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module hdl_cmd_fifo
  import hdl_cmd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  cmd_t                   din,
  input  logic                   pop,
  output cmd_t                   dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hdl_cmd_responder.sv
// HDL-side responder for commands arriving from the SystemC side.
// Commands are queued in a FIFO and executed one at a time against a small
// register file or a cycle-wait timer; each command yields one response
// stamped with the free-running tick count.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   req_valid/req_ready           : command handshake
//   req_op/req_addr/req_data      : command fields (op 0=NOP 1=WRITE 2=READ 3=WAIT)
//   rsp_valid/rsp_ready           : response handshake
//   rsp_op/rsp_data/rsp_err       : executed op, read data, address error
//   rsp_tick                      : tick_count captured on entry to RESP
//   tick_count                    : free-running cycle counter
//   busy                          : FSM active or commands queued
module hdl_cmd_responder
  import hdl_cmd_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int NREGS  = 16,
  parameter int DEPTH  = 4,
  parameter int TICK_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_op,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [TICK_W-1:0] rsp_tick,
  output logic [TICK_W-1:0] tick_count,
  output logic              busy
);

  localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W:0] NREGS_C = (ADDR_W+1)'(NREGS);

  state_e            state;
  cmd_t              cmd;
  cmd_t              fifo_in;
  cmd_t              fifo_head;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              ready_en;
  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] cnt;
  logic              in_range;
  logic [IDX_W-1:0]  idx;

  // ready_en keeps req_ready low throughout reset and raises it one edge later.
  assign req_ready = ready_en && !fifo_full;
  assign fifo_push = req_valid && req_ready;
  assign fifo_pop  = (state == IDLE) && !fifo_empty;
  assign fifo_in   = '{op: op_e'(req_op), addr: req_addr, data: req_data};

  // Full-width compare: addresses at or above NREGS never alias onto a register.
  assign in_range  = ({1'b0, cmd.addr} < NREGS_C);
  assign idx       = cmd.addr[IDX_W-1:0];
  assign busy      = (state != IDLE) || (fifo_count != '0);

  hdl_cmd_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (fifo_in),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_en   <= 1'b0;
      tick_count <= '0;
    end else begin
      ready_en   <= 1'b1;
      tick_count <= tick_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd       <= '0;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_op    <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      rsp_tick  <= '0;
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            cmd   <= fifo_head;
            state <= EXEC;
          end
        end

        EXEC: begin
          rsp_op   <= cmd.op;
          rsp_data <= '0;
          rsp_err  <= 1'b0;
          if (cmd.op == OP_WAIT && cmd.data != '0) begin
            cnt   <= cmd.data;
            state <= WAIT;
          end else begin
            if (cmd.op == OP_WRITE || cmd.op == OP_READ) begin
              if (!in_range) begin
                rsp_err <= 1'b1;
              end else if (cmd.op == OP_WRITE) begin
                regs[idx] <= cmd.data;
              end else begin
                rsp_data <= regs[idx];
              end
            end
            rsp_valid <= 1'b1;
            rsp_tick  <= tick_count;
            state     <= RESP;
          end
        end

        WAIT: begin
          if (cnt == 1) begin
            rsp_valid <= 1'b1;
            rsp_tick  <= tick_count;
            state     <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        RESP: begin
          // Response fields hold until the consumer takes them.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hdl_cmd_responder.sv
// Directed self-checking bench for hdl_cmd_responder.
module tb_hdl_cmd_responder;

  localparam logic [1:0] NOP = 2'd0;
  localparam logic [1:0] WR  = 2'd1;
  localparam logic [1:0] RD  = 2'd2;
  localparam logic [1:0] WT  = 2'd3;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [7:0]  req_addr;
  logic [31:0] req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_op;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] rsp_tick;
  logic [31:0] tick_count;
  logic        busy;

  int checks = 0;
  int fails  = 0;

  hdl_cmd_responder dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_op     (rsp_op),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .rsp_tick   (rsp_tick),
    .tick_count (tick_count),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offer one command; returns the tick_count seen just before the accepting edge.
  task automatic send(input logic [1:0] op, input logic [7:0] addr,
                      input logic [31:0] data, output logic [31:0] t_acc);
    bit done;
    done = 0;
    t_acc = '0;
    req_op = op; req_addr = addr; req_data = data; req_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (req_ready) begin
        t_acc = tick_count;
        done = 1;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    checks++;
    if (!done) begin
      fails++;
      $display("FAIL send_accept: req_ready stayed 0 for op %0d, required 1", op);
    end
  endtask

  // Wait for one response (rsp_ready set by caller); seen = tick_count when first observed.
  task automatic get_rsp(output logic [1:0] op, output logic [31:0] data,
                         output logic err, output logic [31:0] tk, output logic [31:0] seen);
    bit got;
    got = 0;
    op = '0; data = '0; err = 1'b0; tk = '0; seen = '0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1;
        op = rsp_op; data = rsp_data; err = rsp_err; tk = rsp_tick; seen = tick_count;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (!got) begin
      fails++;
      $display("FAIL rsp_timeout: rsp_valid stayed 0, required 1");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = '0; req_addr = '0; req_data = '0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin fails++; $display("FAIL rst_req_ready: got %b, required 0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_rsp_valid: got %b, required 0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b, required 0", busy); end
    checks++; if (tick_count !== 32'd0) begin fails++; $display("FAIL rst_tick: got %0d, required 0", tick_count); end
    checks++; if ({rsp_op, rsp_err, rsp_data, rsp_tick} !== '0) begin
      fails++; $display("FAIL rst_rsp_fields: got op %0d err %b data %h tick %0d, required all 0", rsp_op, rsp_err, rsp_data, rsp_tick);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++; if (tick_count !== 32'd5) begin fails++; $display("FAIL idle_tick: got %0d, required 5", tick_count); end
    checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL idle_req_ready: got %b, required 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL idle_rsp_valid: got %b, required 0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b, required 0", busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    logic [31:0] t0, t1, d1, d2, k1, k2, s1, s2;
    logic [1:0]  o1, o2;
    logic        e1, e2;
    rsp_ready = 1'b1;
    send(WR, 8'd3, 32'hA5A5_0001, t0);
    send(RD, 8'd3, 32'h0, t1);
    get_rsp(o1, d1, e1, k1, s1);
    get_rsp(o2, d2, e2, k2, s2);
    checks++; if (o1 !== WR) begin fails++; $display("FAIL wr_op: got %0d, required 1", o1); end
    checks++; if (d1 !== 32'h0 || e1 !== 1'b0) begin fails++; $display("FAIL wr_rsp: got data %h err %b, required 0/0", d1, e1); end
    checks++; if (k1 !== t0 + 32'd2) begin fails++; $display("FAIL wr_latency: got tick %0d, required %0d", k1, t0 + 32'd2); end
    checks++; if (o2 !== RD) begin fails++; $display("FAIL rd_op: got %0d, required 2", o2); end
    checks++; if (d2 !== 32'hA5A5_0001 || e2 !== 1'b0) begin fails++; $display("FAIL raw_data: got data %h err %b, required a5a50001/0", d2, e2); end
    checks++; if (k2 !== k1 + 32'd3) begin fails++; $display("FAIL rsp_spacing: got tick %0d, required %0d", k2, k1 + 32'd3); end
  endtask

  task automatic test_addr_range();
    logic [31:0] t, d, k, s;
    logic [1:0]  o;
    logic        e;
    send(RD, 8'd20, 32'h0, t); get_rsp(o, d, e, k, s);
    checks++; if (e !== 1'b1 || d !== 32'h0) begin fails++; $display("FAIL rd20: got err %b data %h, required 1/0", e, d); end
    send(RD, 8'd0, 32'h0, t); get_rsp(o, d, e, k, s);
    checks++; if (e !== 1'b0 || d !== 32'h0) begin fails++; $display("FAIL rd0: got err %b data %h, required 0/0", e, d); end
    send(RD, 8'd16, 32'h0, t); get_rsp(o, d, e, k, s);
    checks++; if (e !== 1'b1) begin fails++; $display("FAIL rd16_err: got %b, required 1", e); end
    send(RD, 8'd15, 32'h0, t); get_rsp(o, d, e, k, s);
    checks++; if (e !== 1'b0) begin fails++; $display("FAIL rd15_err: got %b, required 0", e); end
    send(WR, 8'h13, 32'hFFFF_FFFF, t); get_rsp(o, d, e, k, s);
    checks++; if (e !== 1'b1 || d !== 32'h0) begin fails++; $display("FAIL wr19: got err %b data %h, required 1/0", e, d); end
    send(RD, 8'd3, 32'h0, t); get_rsp(o, d, e, k, s);
    checks++; if (d !== 32'hA5A5_0001) begin fails++; $display("FAIL no_alias: got %h, required a5a50001", d); end
  endtask

  task automatic test_wait();
    logic [31:0] t, d, k, s;
    logic [1:0]  o;
    logic        e;
    send(WT, 8'd0, 32'd5, t); get_rsp(o, d, e, k, s);
    checks++; if (k !== t + 32'd7) begin fails++; $display("FAIL wait5_tick: got %0d, required %0d", k, t + 32'd7); end
    checks++; if (s !== t + 32'd8) begin fails++; $display("FAIL wait5_valid_time: got %0d, required %0d", s, t + 32'd8); end
    checks++; if (o !== WT || d !== 32'h0 || e !== 1'b0) begin fails++; $display("FAIL wait5_fields: got op %0d data %h err %b, required 3/0/0", o, d, e); end
    send(WT, 8'd0, 32'd0, t); get_rsp(o, d, e, k, s);
    checks++; if (k !== t + 32'd2) begin fails++; $display("FAIL wait0_tick: got %0d, required %0d", k, t + 32'd2); end
    checks++; if (s !== t + 32'd3) begin fails++; $display("FAIL wait0_valid_time: got %0d, required %0d", s, t + 32'd3); end
    send(WT, 8'd0, 32'd1, t); get_rsp(o, d, e, k, s);
    checks++; if (k !== t + 32'd3) begin fails++; $display("FAIL wait1_tick: got %0d, required %0d", k, t + 32'd3); end
  endtask

  task automatic test_backpressure();
    int          acc;
    int          late;
    logic [31:0] t0, vt, d, k, s, prev;
    logic [1:0]  o;
    logic        e;
    acc = 0; t0 = '0; late = 0; prev = '0;
    rsp_ready = 1'b0;
    req_op = NOP; req_addr = '0; req_data = '0; req_valid = 1'b1;
    for (int i = 0; i < 8 && acc < 6; i++) begin
      @(negedge clk);
      if (req_ready) begin
        if (acc == 0) t0 = tick_count;
        acc++;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    checks++; if (acc !== 5) begin fails++; $display("FAIL bp_accepted: got %0d, required 5", acc); end
    @(negedge clk);
    vt = rsp_tick;
    checks++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL bp_valid: got %b, required 1", rsp_valid); end
    checks++; if (req_ready !== 1'b0) begin fails++; $display("FAIL bp_req_ready: got %b, required 0", req_ready); end
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL bp_busy: got %b, required 1", busy); end
    checks++; if (vt !== t0 + 32'd2) begin fails++; $display("FAIL bp_tick: got %0d, required %0d", vt, t0 + 32'd2); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_tick !== vt || rsp_op !== NOP || rsp_data !== 32'h0 || rsp_err !== 1'b0) begin
        fails++;
        $display("FAIL bp_stable: got valid %b tick %0d op %0d data %h err %b, required 1/%0d/0/0/0", rsp_valid, rsp_tick, rsp_op, rsp_data, rsp_err, vt);
      end
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      get_rsp(o, d, e, k, s);
      checks++; if (o !== NOP || e !== 1'b0) begin fails++; $display("FAIL drain_%0d: got op %0d err %b, required 0/0", n, o, e); end
      if (n == 0) begin
        checks++; if (k !== vt) begin fails++; $display("FAIL drain_first_tick: got %0d, required %0d", k, vt); end
      end else if (n >= 2) begin
        checks++; if (k !== prev + 32'd3) begin fails++; $display("FAIL drain_spacing_%0d: got %0d, required %0d", n, k, prev + 32'd3); end
      end
      prev = k;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) late++;
      @(posedge clk); #1;
    end
    checks++; if (late !== 0) begin fails++; $display("FAIL drain_extra: got %0d extra valid cycles, required 0", late); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL drain_busy: got %b, required 0", busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_wait();
    int          seen;
    logic [31:0] t, d, k, s;
    logic [1:0]  o;
    logic        e;
    seen = 0;
    rsp_ready = 1'b1;
    send(WT, 8'd0, 32'd100, t);
    send(NOP, 8'd0, 32'd0, t);
    send(NOP, 8'd0, 32'd0, t);
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) seen++;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (tick_count !== 32'd0) begin fails++; $display("FAIL mid_rst_tick: got %0d, required 0", tick_count); end
    checks++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL mid_rst_ctrl: got ready %b valid %b busy %b, required 0/0/0", req_ready, rsp_valid, busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (tick_count !== 32'd1) begin fails++; $display("FAIL restart_tick: got %0d, required 1", tick_count); end
    checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL restart_ctrl: got ready %b busy %b, required 1/0", req_ready, busy); end
    @(posedge clk); #1;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 0) begin fails++; $display("FAIL aborted_rsp: got %0d valid cycles, required 0", seen); end
    send(RD, 8'd3, 32'h0, t); get_rsp(o, d, e, k, s);
    checks++; if (d !== 32'h0 || e !== 1'b0) begin fails++; $display("FAIL reg_cleared: got data %h err %b, required 0/0", d, e); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_addr_range();
    test_wait();
    test_backpressure();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
